// File: rtl/sramlike_axi_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 multi-channel arbiter.
package sramlike_axi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRaddr,
      StRdata,
      StWreq,
      StWresp
   } state_e;

   typedef enum logic [1:0] {
      SizeByte = 2'd0,
      SizeHalf = 2'd1,
      SizeWord = 2'd2
   } size_e;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam int unsigned AXI_ID_W       = 4;

endpackage

// File: rtl/sramlike_axi_arbiter_rr_arbiter.sv
// Channel arbiter: round-robin when SRAMLIKE_AXI_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 2,
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_adv,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [IDX_W-1:0]  o_idx
);

   logic [NUM_CH-1:0] w_pick;
   logic              w_found;

`ifdef SRAMLIKE_AXI_RR_ARB_EN
   logic [IDX_W-1:0]  r_ptr;
   logic [NUM_CH-1:0] w_mask;
   logic [NUM_CH-1:0] w_req_hi;

   // Requests at or above the pointer win first; wrap to the full vector otherwise.
   assign w_mask   = ~((NUM_CH'(1) << r_ptr) - NUM_CH'(1));
   assign w_req_hi = i_req & w_mask;
   assign w_pick   = (|w_req_hi) ? w_req_hi : i_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (o_idx == IDX_W'(NUM_CH - 1)) ? '0 : o_idx + 1'b1;
      end
   end
`else
   logic w_unused;

   assign w_pick   = i_req;
   assign w_unused = i_clk ^ i_rst ^ i_adv;
`endif

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_pick[i] && !w_found) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_idx    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/sramlike_axi_arbiter.sv
// NUM_CH SRAM-like channels onto one AXI3 master, one transaction at a time.
// SRAMLIKE_AXI_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module sramlike_axi_arbiter
   import sramlike_axi_pkg::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     ch_req,
   input  logic [NUM_CH-1:0]     ch_wr,
   input  logic [NUM_CH*2-1:0]   ch_size,
   input  logic [NUM_CH*4-1:0]   ch_len,
   input  logic [NUM_CH*32-1:0]  ch_addr,
   input  logic [NUM_CH*4-1:0]   ch_wen,
   input  logic [NUM_CH*32-1:0]  ch_wdata,
   output logic [NUM_CH-1:0]     ch_addr_ok,
   output logic [NUM_CH-1:0]     ch_data_ok,
   output logic [31:0]           ch_rdata,
   output logic [3:0]            arid,
   output logic [31:0]           araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [1:0]            arlock,
   output logic [3:0]            arcache,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [3:0]            rid,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [3:0]            awid,
   output logic [31:0]           awaddr,
   output logic [3:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [1:0]            awlock,
   output logic [3:0]            awcache,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [3:0]            wid,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [3:0]            bid,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [3:0]  LEN_CAP = 4'(MAX_LEN - 1);

   state_e              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [1:0]          r_size;
   logic [3:0]          r_len;
   logic [31:0]         r_addr;
   logic [3:0]          r_wen;
   logic [31:0]         r_wdata;
   logic                r_aw_done, r_w_done;
   logic                w_aw_done_nxt, w_w_done_nxt;

   logic [NUM_CH-1:0]   w_arb_req, w_gnt;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic                w_grant;
   logic                w_sel_wr;
   logic [1:0]          w_sel_size;
   logic [3:0]          w_sel_len, w_len_clamped;
   logic [31:0]         w_sel_addr, w_sel_wdata;
   logic [3:0]          w_sel_wen;
   logic [AXI_ID_W-1:0] w_id;
   logic                w_rmatch;
   logic                w_unused;

   // No grant while in reset so a requester never sees a spurious accept.
   assign w_arb_req = (r_state == StIdle && !rst) ? ch_req : '0;
   assign w_grant   = |w_gnt;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .i_clk (clk),
      .i_rst (rst),
      .i_req (w_arb_req),
      .i_adv (w_grant),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx)
   );

   always_comb begin
      w_sel_wr    = 1'b0;
      w_sel_size  = '0;
      w_sel_len   = '0;
      w_sel_addr  = '0;
      w_sel_wen   = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gnt[i]) begin
            w_sel_wr    = ch_wr[i];
            w_sel_size  = ch_size[2*i +: 2];
            w_sel_len   = ch_len[4*i +: 4];
            w_sel_addr  = ch_addr[32*i +: 32];
            w_sel_wen   = ch_wen[4*i +: 4];
            w_sel_wdata = ch_wdata[32*i +: 32];
         end
      end
      w_len_clamped = ({28'd0, w_sel_len} >= MAX_LEN) ? LEN_CAP : w_sel_len;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_idx     <= '0;
         r_size    <= '0;
         r_len     <= '0;
         r_addr    <= '0;
         r_wen     <= '0;
         r_wdata   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         if (w_grant) begin
            r_idx   <= w_gnt_idx;
            r_size  <= w_sel_size;
            r_len   <= w_len_clamped;
            r_addr  <= w_sel_addr;
            r_wen   <= w_sel_wen;
            r_wdata <= w_sel_wdata;
         end
      end
   end

   assign w_id     = AXI_ID_W'(r_idx);
   assign w_rmatch = (rid == w_id);

   always_comb begin
      w_state_nxt   = r_state;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      arvalid       = 1'b0;
      rready        = 1'b0;
      awvalid       = 1'b0;
      wvalid        = 1'b0;
      bready        = 1'b0;
      ch_data_ok    = '0;
      ch_rdata      = '0;
      unique case (r_state)
         StIdle: begin
            if (w_grant) w_state_nxt = w_sel_wr ? StWreq : StRaddr;
         end
         StRaddr: begin
            arvalid = 1'b1;
            if (arready) w_state_nxt = StRdata;
         end
         StRdata: begin
            rready = 1'b1;
            // Beats for another ID are accepted and discarded.
            if (rvalid && w_rmatch) begin
               ch_data_ok[r_idx] = 1'b1;
               ch_rdata          = rdata;
               if (rlast) w_state_nxt = StIdle;
            end
         end
         StWreq: begin
            awvalid       = !r_aw_done;
            wvalid        = !r_w_done;
            w_aw_done_nxt = r_aw_done | awready;
            w_w_done_nxt  = r_w_done | wready;
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_state_nxt   = StWresp;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
         StWresp: begin
            bready = 1'b1;
            if (bvalid) begin
               ch_data_ok[r_idx] = 1'b1;
               w_state_nxt       = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign ch_addr_ok = w_gnt;

   assign arid    = w_id;
   assign araddr  = r_addr;
   assign arlen   = {4'd0, r_len};
   assign arsize  = {1'b0, r_size};
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = w_id;
   assign awaddr  = r_addr;
   assign awlen   = 4'd0;
   assign awsize  = {1'b0, r_size};
   assign awburst = AXI_BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid     = w_id;
   assign wdata   = r_wdata;
   assign wstrb   = r_wen;
   assign wlast   = (r_state == StWreq);

   // Response codes and BID carry nothing this bridge acts on.
   assign w_unused = ^{rresp, bresp, bid};

endmodule

// File: doc/sramlike_axi_arbiter.md
# sramlike_axi_arbiter

Parametrised successor to the two-port SRAM-like-to-AXI bridge. It accepts NUM_CH independent SRAM-like master channels (I-fetch, D-access, cache refill, uncached, etc.) and arbitrates among them. It issues one AXI3 transaction at a time, either a multi-beat read burst or a single-beat write, and returns read data and completion to the owning channel. It sits between the CPU-side memory ports and the SoC AXI crossbar.

## Interface
Parameters:
- NUM_CH, 2: number of SRAM-like channels (2..8); also the AXI ID space, with `arid`/`awid` = channel index.
- MAX_LEN, 16: largest read burst in beats; `ch_len` values at or above MAX_LEN are clamped to MAX_LEN-1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ch_req  in  NUM_CH  per-channel request
- ch_wr  in  NUM_CH  1 = write, 0 = read
- ch_size  in  NUM_CH×2  0 = byte, 1 = half, 2 = word
- ch_len  in  NUM_CH×4  read beats minus 1; ignored for writes
- ch_addr  in  NUM_CH×32  byte address
- ch_wen  in  NUM_CH×4  write byte strobes
- ch_wdata  in  NUM_CH×32  write data
- ch_addr_ok  out  NUM_CH  request accepted (one-hot)
- ch_data_ok  out  NUM_CH  read beat valid / write complete (one-hot)
- ch_rdata  out  32  read data, shared by all channels, qualified by `ch_data_ok`
- AR/R/AW/W/B channels: the full AXI3 master set with the same names and widths as the existing bridge (`arlen` 8 bits, `awlen` 4 bits, `arlock`/`awlock` 2 bits, `wid` 4 bits).

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - If any `ch_req` is high, the arbiter picks channel g.
  - `ch_addr_ok[g]`=1 in the same cycle (combinational). Request fields are latched.
  - Next state is WREQ if `ch_wr[g]`=1, otherwise RADDR.
- RADDR:
  - `arvalid`=1; `araddr`, `arsize`={0,size}, `arlen`=len, `arburst`=01, `arid`=g.
  - `arready` → RDATA.
- RDATA:
  - `rready`=1.
  - Each `rvalid` with `rid`==g gives `ch_data_ok[g]`=1 and `ch_rdata`=`rdata`.
  - `rlast` → IDLE.
  - A beat with `rid`≠g is acknowledged and dropped.
- WREQ:
  - `awvalid` and `wvalid` are raised together. `wlast`=1, `awlen`=0, `wstrb`=wen, `wid`=`awid`=g.
  - Each valid drops independently on its own ready (aw_done and w_done flags).
  - When both are done → WRESP.
- WRESP:
  - `bready`=1.
  - `bvalid` gives `ch_data_ok[g]`=1 → IDLE.
- `rresp`/`bresp` errors are ignored; data is still delivered.
- Constant outputs: `arcache`/`awcache`=0, `arprot`/`awprot`=0, `arlock`/`awlock`=0.
- A channel must hold `ch_req` and its fields until `ch_addr_ok`. It must not issue a new request before its `ch_data_ok` (last beat or B).
- Simultaneous requests: only one is granted per IDLE cycle. Losers keep `ch_req` high and see `ch_addr_ok`=0.
- Reset mid-transaction: FSM returns to IDLE and all valid/ready outputs drop. The AXI slave is reset by the same `rst`.

## Timing
- Reset values:
  - All outputs 0, except `arburst`=`awburst`=01.
  - State IDLE; round-robin pointer 0.
- Minimum read, single beat: `ch_addr_ok` at T, `arvalid` at T+1 (ready same cycle), `ch_data_ok` at T+2.
- Minimum write: `ch_addr_ok` at T, aw/w accepted at T+1, `ch_data_ok` at T+2 (if `bvalid` is already high).
- Back-to-back: the next grant happens the cycle after return to IDLE. There is no idle bubble beyond the state transition.
- `ch_rdata` and `ch_data_ok` are combinational from `rdata`/`rvalid`/`bvalid`; there is no extra register stage.

## Configuration
- `SRAMLIKE_AXI_RR_ARB_EN` defined: round-robin arbitration. After granting g, the pointer moves to (g+1) mod NUM_CH, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins. The pointer register is compiled out.

## Structure
- Package `sramlike_axi_pkg` holds:
  - the FSM state enum;
  - `AXI_BURST_INCR`=2'b01;
  - size encodings;
  - `AXI_ID_W`=4.
- Sub-module `rr_arbiter`, parametrised NUM_CH:
  - inputs: request vector and advance strobe;
  - outputs: one-hot grant and binary index.
  - It contains both arbitration modes under the macro.

## Test plan
- Single read on ch0, addr 0x1FC0_0000, len 0; slave returns 0xDEADBEEF → `ch_addr_ok[0]` at T, `araddr`=0x1FC0_0000 with `arid`=0, `ch_data_ok[0]` with rdata 0xDEADBEEF at T+2.
- Burst read on ch1, len 3, addr 0x0000_1000 → `arlen`=3; four `ch_data_ok[1]` pulses carrying the beat data in order; return to IDLE after `rlast`.
- Write on ch0, addr 0xBFAF_F000, wen 4'b0011, wdata 0x1234_5678; slave delays `awready` 3 cycles while `wready` is immediate → `wvalid` drops after 1 cycle, `awvalid` is held; `ch_data_ok[0]` only on `bvalid`.
- ch0 and ch1 request reads continuously:
  - RR mode: grants alternate 0,1,0,1.
  - Fixed mode: ch0 wins every time.
- `rst` asserted during RDATA after beat 2 of 4 → next cycle all outputs are at reset values and state is IDLE; a subsequent ch1 read completes normally.
